// File: rtl/dds_phase_ctrl_if.sv
// dds_phase_ctrl_if -- control/status bundle for the DDS phase controller.
//
// master (driver side):
//   en           run enable
//   sync_clr     synchronous phase clear
//   ftw_in       frequency tuning word
//   ftw_load     one-cycle strobe capturing ftw_in
// slave (controller side) returns:
//   ftw_busy     captured word waiting to be applied
//   sign_bit     half-cycle select (acc MSB)
//   phase_pose   quadrant-mirror select (acc MSB-1)
//   addr         6-bit quarter-wave ROM address
//   sample_valid one-cycle pulse per phase update
//   cycle_wrap   one-cycle pulse per accumulator carry-out
interface dds_phase_ctrl_if #(
  parameter int ACC_W = 16
);
  logic             en;
  logic             sync_clr;
  logic [ACC_W-1:0] ftw_in;
  logic             ftw_load;
  logic             ftw_busy;
  logic             sign_bit;
  logic             phase_pose;
  logic [5:0]       addr;
  logic             sample_valid;
  logic             cycle_wrap;

  modport master (
    output en, sync_clr, ftw_in, ftw_load,
    input  ftw_busy, sign_bit, phase_pose, addr, sample_valid, cycle_wrap
  );

  modport slave (
    input  en, sync_clr, ftw_in, ftw_load,
    output ftw_busy, sign_bit, phase_pose, addr, sample_valid, cycle_wrap
  );
endinterface

// File: rtl/dds_phase_ctrl.sv
// dds_phase_ctrl -- phase accumulator and tuning-word control for a
// quarter-wave-ROM DDS.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dds_phase_ctrl_if.slave (control inputs, phase/status outputs)
//
// A new tuning word is held pending while running and only takes effect on
// the edge where the accumulator wraps, so the output never changes
// frequency mid-cycle. While idle (or on a phase clear) it applies at once.
module dds_phase_ctrl #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dds_phase_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] ftw_act_reg;
  logic [ACC_W-1:0] ftw_pend_reg;
  logic             pend_reg;
  logic             sample_valid_reg;
  logic             cycle_wrap_reg;

  logic [ACC_W:0]   sum_next;
  logic             carry;
  logic             update;
  logic             apply_edge;

  always_comb begin
    sum_next   = {1'b0, acc_reg} + {1'b0, ftw_act_reg};
    carry      = sum_next[ACC_W];
    update     = (state_reg == RUN) && bus.en && !bus.sync_clr;
    // The carrying update still uses the old word; the new one lands on
    // that same edge.
    apply_edge = pend_reg &&
                 ((state_reg == IDLE) || bus.sync_clr || (update && carry));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      ftw_act_reg      <= '0;
      ftw_pend_reg     <= '0;
      pend_reg         <= 1'b0;
      sample_valid_reg <= 1'b0;
      cycle_wrap_reg   <= 1'b0;
    end else begin
      state_reg        <= bus.en ? RUN : IDLE;
      sample_valid_reg <= update;
      cycle_wrap_reg   <= update && carry;

      if (bus.sync_clr) begin
        acc_reg <= '0;
      end else if (update) begin
        acc_reg <= sum_next[ACC_W-1:0];
      end

      if (bus.ftw_load) begin
        ftw_pend_reg <= bus.ftw_in;
      end

      if (apply_edge) begin
        // A strobe landing on the apply edge supersedes the pending word.
        ftw_act_reg <= bus.ftw_load ? bus.ftw_in : ftw_pend_reg;
        pend_reg    <= 1'b0;
      end else if (bus.ftw_load) begin
        pend_reg    <= 1'b1;
      end
    end
  end

  assign bus.sign_bit     = acc_reg[ACC_W-1];
  assign bus.phase_pose   = acc_reg[ACC_W-2];
  assign bus.addr         = acc_reg[ACC_W-3:ACC_W-8];
  assign bus.ftw_busy     = pend_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.cycle_wrap   = cycle_wrap_reg;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb_dds_phase_ctrl -- directed, table-driven bench for dds_phase_ctrl.
module tb_dds_phase_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dds_phase_ctrl_if #(.ACC_W(16)) bus ();

  dds_phase_ctrl #(.ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        clr;
    logic        ld;
    logic [15:0] ftw;
    logic        busy;
    logic [7:0]  hi;
    logic        sv;
    logic        cw;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] acc_hi();
    return {bus.sign_bit, bus.phase_pose, bus.addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic clr, input logic ld, input logic [15:0] ftw);
    bus.en       = en;
    bus.sync_clr = clr;
    bus.ftw_load = ld;
    bus.ftw_in   = ftw;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {24'd0, acc_hi(), bus.ftw_busy, bus.sample_valid, bus.cycle_wrap}, 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load a word while idle, then enable: first edge captures, second applies
  // and enters RUN; the accumulator is still zero afterwards.
  task automatic start_run(input logic [15:0] ftw);
    drive(1'b0, 1'b0, 1'b1, ftw);
    tick();
    chk("idle_load_busy", {31'd0, bus.ftw_busy}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("idle_apply", {23'd0, bus.ftw_busy, acc_hi()}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk_all_zero("reset_async_initial");

    // ---------------- table: idle load, coincident load, clear ----------
    //              en    clr   ld    ftw        busy  hi     sv    cw
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0300, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].ftw);
      tick();
      $display("vec %0d en=%0b clr=%0b ld=%0b ftw=%04h -> hi=%02h sv=%0b cw=%0b busy=%0b",
               i, vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].ftw,
               acc_hi(), bus.sample_valid, bus.cycle_wrap, bus.ftw_busy);
      chk($sformatf("vec%0d_hi", i), {24'd0, acc_hi()}, {24'd0, vecs[i].hi});
      chk($sformatf("vec%0d_sv", i), {31'd0, bus.sample_valid}, {31'd0, vecs[i].sv});
      chk($sformatf("vec%0d_cw", i), {31'd0, bus.cycle_wrap}, {31'd0, vecs[i].cw});
      chk($sformatf("vec%0d_busy", i), {31'd0, bus.ftw_busy}, {31'd0, vecs[i].busy});
    end

    // ---------------- basic ramp at 0x0100 ----------------
    begin
      int wraps;
      logic [7:0] e;
      wraps = 0;
      do_reset();
      start_run(16'h0100);
      for (int i = 1; i <= 300; i++) begin
        tick();
        e = 8'(i);
        chk("ramp_hi", {24'd0, acc_hi()}, {24'd0, e});
        chk("ramp_sv", {31'd0, bus.sample_valid}, 32'd1);
        chk("ramp_cw", {31'd0, bus.cycle_wrap}, (i == 256) ? 32'd1 : 32'd0);
        if (bus.cycle_wrap) wraps++;
        if (i == 63)  chk("ramp_pose_63", {31'd0, bus.phase_pose}, 32'd0);
        if (i == 64)  chk("ramp_pose_64", {31'd0, bus.phase_pose}, 32'd1);
        if (i == 127) chk("ramp_sign_127", {31'd0, bus.sign_bit}, 32'd0);
        if (i == 128) chk("ramp_sign_128", {31'd0, bus.sign_bit}, 32'd1);
      end
      $display("ramp done wraps=%0d", wraps);
      chk("ramp_wrap_count", wraps, 32'd1);
    end

    // ---------------- deferred retune ----------------
    do_reset();
    start_run(16'h0100);
    repeat (64) tick();
    chk("retune_at_4000", {24'd0, acc_hi()}, 32'h40);
    drive(1'b1, 1'b0, 1'b1, 16'h0200);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("retune_load_hi", {24'd0, acc_hi()}, 32'h41);
    chk("retune_load_busy", {31'd0, bus.ftw_busy}, 32'd1);
    for (int k = 8'h42; k <= 8'hFF; k++) begin
      tick();
      chk("retune_wait_hi", {24'd0, acc_hi()}, k);
      chk("retune_wait_busy", {31'd0, bus.ftw_busy}, 32'd1);
    end
    tick();
    $display("retune wrap hi=%02h cw=%0b busy=%0b", acc_hi(), bus.cycle_wrap, bus.ftw_busy);
    chk("retune_wrap_hi", {24'd0, acc_hi()}, 32'h00);
    chk("retune_wrap_cw", {31'd0, bus.cycle_wrap}, 32'd1);
    chk("retune_wrap_busy", {31'd0, bus.ftw_busy}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("retune_step2_hi", {24'd0, acc_hi()}, 2 * k);
      chk("retune_step2_cw", {31'd0, bus.cycle_wrap}, 32'd0);
    end

    // ---------------- double load before wrap ----------------
    begin
      logic [7:0] exp_hi [4];
      exp_hi[0] = 8'h00; exp_hi[1] = 8'h01; exp_hi[2] = 8'h01; exp_hi[3] = 8'h02;
      do_reset();
      start_run(16'h4000);
      tick();
      chk("dbl_4000", {24'd0, acc_hi()}, 32'h40);
      drive(1'b1, 1'b0, 1'b1, 16'h0300);
      tick();
      chk("dbl_load1_busy", {31'd0, bus.ftw_busy}, 32'd1);
      drive(1'b1, 1'b0, 1'b1, 16'h0080);
      tick();
      chk("dbl_load2_hi", {24'd0, acc_hi()}, 32'hC0);
      chk("dbl_load2_busy", {31'd0, bus.ftw_busy}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
      chk("dbl_wrap_cw", {31'd0, bus.cycle_wrap}, 32'd1);
      chk("dbl_wrap_busy", {31'd0, bus.ftw_busy}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        $display("dbl step %0d hi=%02h", k, acc_hi());
        chk("dbl_after_hi", {24'd0, acc_hi()}, {24'd0, exp_hi[k]});
      end
    end

    // ---------------- sync_clr at 0xA000 ----------------
    do_reset();
    start_run(16'h2000);
    repeat (5) tick();
    chk("clr_at_a000", {24'd0, acc_hi()}, 32'hA0);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    chk("clr_hi", {24'd0, acc_hi()}, 32'h00);
    chk("clr_sv", {31'd0, bus.sample_valid}, 32'd0);
    chk("clr_cw", {31'd0, bus.cycle_wrap}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("clr_next_hi", {24'd0, acc_hi()}, 32'h20);
    chk("clr_next_sv", {31'd0, bus.sample_valid}, 32'd1);
    tick();
    chk("clr_next2_hi", {24'd0, acc_hi()}, 32'h40);

    // ---------------- reset mid-run with pending word ----------------
    do_reset();
    start_run(16'h7F00);
    drive(1'b1, 1'b0, 1'b1, 16'h0100);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("midrst_pre_hi", {24'd0, acc_hi()}, 32'h7F);
    chk("midrst_pre_busy", {31'd0, bus.ftw_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst_immediate");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrst_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_first_edge", {29'd0, acc_hi() != 8'd0, bus.ftw_busy, bus.sample_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("midrst run %0d hi=%02h sv=%0b cw=%0b busy=%0b",
               k, acc_hi(), bus.sample_valid, bus.cycle_wrap, bus.ftw_busy);
      chk("midrst_hold_hi", {24'd0, acc_hi()}, 32'h00);
      chk("midrst_hold_sv", {31'd0, bus.sample_valid}, 32'd1);
      chk("midrst_hold_cw", {31'd0, bus.cycle_wrap}, 32'd0);
      chk("midrst_hold_busy", {31'd0, bus.ftw_busy}, 32'd0);
    end

    // ---------------- overflow stride 0xFFFF ----------------
    begin
      logic [15:0] e;
      do_reset();
      start_run(16'hFFFF);
      for (int k = 1; k <= 300; k++) begin
        tick();
        e = 16'(17'h10000 - 17'(k));
        chk("ovf_hi", {24'd0, acc_hi()}, {24'd0, e[15:8]});
        chk("ovf_cw", {31'd0, bus.cycle_wrap}, (k > 1) ? 32'd1 : 32'd0);
        chk("ovf_sv", {31'd0, bus.sample_valid}, 32'd1);
      end
      $display("overflow stride done hi=%02h", acc_hi());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
